mem_exc_arb: RTL and testbench
==============================

# mem_exc_arb

Exception arbiter at the MEM/WB boundary of the MiniMIPS32 core. It collects per-instruction exception flags raised by earlier stages, samples hardware and timer interrupts, and resolves them against CP0 Status/Cause. It drives the registered exception record (`exccode`, faulting PC, bad address, delay-slot bit) consumed by the CP0 register file, which generates flush and the handler address. It also blanks the record for one cycle after every flush.

## Interface
- `INT_NUM`, 6: number of hardware interrupt lines (IP7..IP2).
- `EXC_NONE`, 5'h10 / `EXC_ERET`, 5'h11 / `EXC_INT`, 5'h00 / `EXC_ADEL`, 5'h04 / `EXC_ADES`, 5'h05 / `EXC_SYS`, 5'h08 / `EXC_BP`, 5'h09 / `EXC_RI`, 5'h0a / `EXC_OV`, 5'h0c: exception codes.

Ports:
- `cpu_clk_50M` in 1: core clock.
- `cpu_rst` in 1: asynchronous, active-high reset.
- `mem_valid_i` in 1: MEM holds a real instruction, not a bubble.
- `mem_pc_i` in 32: PC of the MEM instruction.
- `mem_in_delay_i` in 1: MEM instruction sits in a delay slot.
- `mem_exc_i` in 8: raw flags `{if_adel, ri, sys, bp, ov, ld_adel, st_ades, eret}` (bit 7..0).
- `mem_daddr_i` in 32: data address of the MEM load/store.
- `cp0_status_i`, `cp0_cause_i` in 32: current CP0 Status/Cause.
- `cp0_we_i` in 1, `cp0_waddr_i` in 5, `cp0_wdata_i` in 32: mtc0 being committed in CP0 this cycle.
- `hw_int_i` in 6: asynchronous external interrupt lines.
- `timer_int_i` in 1: CP0 timer interrupt.
- `int_o` out 6: interrupt pending vector to CP0 Cause[15:10].
- `exccode_o` out 5: registered exception code.
- `exc_pc_o` out 32: registered faulting PC.
- `exc_badvaddr_o` out 32: registered bad virtual address.
- `exc_in_delay_o` out 1: registered delay-slot flag.

## Operation
- `int_o = {hw_int_s[5] | timer_int_i, hw_int_s[4:0]}`. `hw_int_s` is the synchronised `hw_int_i` (see Configuration).
- Effective Status: on `cp0_we_i && cp0_waddr_i==12`, bits [15:8] and [1:0] come from `cp0_wdata_i`; all other bits come from `cp0_status_i`.
- Effective Cause: on `cp0_we_i && cp0_waddr_i==13`, bits [9:8] come from `cp0_wdata_i`. Bits [15:10] always come from `int_o`.
- `int_req = IE & ~EXL & |(IP[7:0] & IM[7:0])`, computed on the effective values.
- Arbitration applies only when `mem_valid_i=1`. Priority, highest first: INT, `if_adel`, RI, SYS, BP, OV, `ld_adel`, `st_ades`, ERET. If none applies, the code is `EXC_NONE`.
- Bad address is `mem_pc_i` for `if_adel` and `mem_daddr_i` for `ld_adel`/`st_ades`; otherwise 0.
- When an interrupt is requested but `mem_valid_i=0`, the request is not lost. It is re-evaluated each cycle until it attaches to the next valid instruction.
- FSM, two states:
  - RUN: capture the arbitration result into the output registers. If the captured code is not `EXC_NONE`, go to BLANK.
  - BLANK: capture `EXC_NONE`; PC, badvaddr and delay flag capture 0. Return to RUN unconditionally.
- Any valid instruction in MEM during BLANK is squashed by the CP0 flush. Its flags are discarded.

## Timing
- Reset values: `exccode_o=EXC_NONE`, `exc_pc_o=0`, `exc_badvaddr_o=0`, `exc_in_delay_o=0`, FSM=RUN, synchroniser flops=0. `int_o` resets to `{timer_int_i, 5'b0}`.
- Latency: MEM flags to `exccode_o` is 1 cycle. CP0 then flushes combinationally in that same output cycle.
- Back-to-back excepting instructions: the second instruction is always blanked, so at most one non-NONE code is produced every 2 cycles.
- mtc0 unmasking interrupts in cycle N while an interrupt is pending: a valid MEM instruction in cycle N receives `EXC_INT` at N+1.
- mtc0 setting EXL or clearing IE in cycle N: the interrupt is suppressed in cycle N.
- `eret` together with a higher-priority flag: the higher-priority code wins.
- Asserting `cpu_rst` mid-BLANK forces RUN and the reset values immediately.

## Configuration
- `INT_SYNC_EN` defined: `hw_int_i` passes through a 2-flop synchroniser. The line-to-`int_o` latency is 2 cycles.
- `INT_SYNC_EN` undefined: `hw_int_s = hw_int_i` combinationally, with 0-cycle latency. Use this only when the lines are already synchronous.
- `timer_int_i` is never synchronised in either configuration.

## Test plan
- Status=0x1000FF01, `hw_int_i[0]` rises, `mem_valid_i=1`, `mem_pc_i=0xBFC00100` (with `INT_SYNC_EN`): `exccode_o=0x00` and `exc_pc_o=0xBFC00100` appear 3 cycles after the edge; the next cycle shows `EXC_NONE`.
- `mem_exc_i=8'b0000_1001` (OV+ERET), `mem_pc_i=0x80000010`: next cycle `exccode_o=0x0C`.
- `mem_exc_i` bit 1 (`st_ades`), `mem_daddr_i=0x80000003`: `exccode_o=0x05`, `exc_badvaddr_o=0x80000003`.
- Interrupt pending while `mem_valid_i=0` for 3 cycles, then a valid instruction at 0x80000020 with `in_delay=1`: `exccode_o=0x00`, `exc_pc_o=0x80000020`, `exc_in_delay_o=1`.
- Pending IP2 with Status IM=0, mtc0 writes Status=0x1000FF01 in cycle N with a valid MEM instruction: `EXC_INT` at N+1.
- Two consecutive SYS instructions: `0x08` then `EXC_NONE`. Assert `cpu_rst` during the BLANK cycle: outputs return to reset values immediately.

Source files
------------

// File: rtl/mem_exc_arb.sv
// ============================================================================
// Module   : mem_exc_arb
// Purpose  : MEM/WB exception arbiter for the MiniMIPS32 core. It collects the
//            per-instruction exception flags, samples hardware and timer
//            interrupts, resolves them against CP0 Status/Cause, and drives
//            the registered exception record consumed by CP0. After every
//            non-NONE record it blanks the record for one cycle (flush shadow).
// Ports    : cpu_clk_50M, cpu_rst (async, active-high)
//            mem_valid_i, mem_pc_i, mem_in_delay_i, mem_exc_i, mem_daddr_i
//            cp0_status_i, cp0_cause_i, cp0_we_i, cp0_waddr_i, cp0_wdata_i
//            hw_int_i, timer_int_i
//            int_o, exccode_o, exc_pc_o, exc_badvaddr_o, exc_in_delay_o
// Config   : INT_SYNC_EN - when defined, hw_int_i passes through a 2-flop
//            synchroniser (2-cycle latency); otherwise it is used directly.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_exc_arb #(
  parameter int INT_NUM = 6
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst,
  input  logic               mem_valid_i,
  input  logic [31:0]        mem_pc_i,
  input  logic               mem_in_delay_i,
  input  logic [7:0]         mem_exc_i,
  input  logic [31:0]        mem_daddr_i,
  input  logic [31:0]        cp0_status_i,
  input  logic [31:0]        cp0_cause_i,
  input  logic               cp0_we_i,
  input  logic [4:0]         cp0_waddr_i,
  input  logic [31:0]        cp0_wdata_i,
  input  logic [INT_NUM-1:0] hw_int_i,
  input  logic               timer_int_i,
  output logic [INT_NUM-1:0] int_o,
  output logic [4:0]         exccode_o,
  output logic [31:0]        exc_pc_o,
  output logic [31:0]        exc_badvaddr_o,
  output logic               exc_in_delay_o
);

  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_BLANK = 1'b1;

  // --------------------------------------------------------------------------
  // Hardware interrupt lines (optionally synchronised)
  // --------------------------------------------------------------------------
  logic [INT_NUM-1:0] hw_int_s;

`ifdef INT_SYNC_EN
  logic [INT_NUM-1:0] sync1_q;
  logic [INT_NUM-1:0] sync2_q;

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hw_int_i;
      sync2_q <= sync1_q;
    end
  end

  assign hw_int_s = sync2_q;
`else
  assign hw_int_s = hw_int_i;
`endif

  // Timer shares IP7 with the top hardware line.
  assign int_o = {hw_int_s[INT_NUM-1] | timer_int_i, hw_int_s[INT_NUM-2:0]};

  // --------------------------------------------------------------------------
  // Effective Status/Cause: an mtc0 committing this cycle must be honoured
  // now, otherwise an unmask/mask would act one instruction late.
  // --------------------------------------------------------------------------
  logic        status_wr_w;
  logic        cause_wr_w;
  logic [7:0]  im_w;
  logic        exl_w;
  logic        ie_w;
  logic [1:0]  ip_sw_w;
  logic [7:0]  ip_w;
  logic        int_req_w;

  assign status_wr_w = cp0_we_i && (cp0_waddr_i == 5'd12);
  assign cause_wr_w  = cp0_we_i && (cp0_waddr_i == 5'd13);

  assign im_w    = status_wr_w ? cp0_wdata_i[15:8] : cp0_status_i[15:8];
  assign exl_w   = status_wr_w ? cp0_wdata_i[1]    : cp0_status_i[1];
  assign ie_w    = status_wr_w ? cp0_wdata_i[0]    : cp0_status_i[0];
  assign ip_sw_w = cause_wr_w  ? cp0_wdata_i[9:8]  : cp0_cause_i[9:8];
  assign ip_w    = {int_o, ip_sw_w};

  // Level-based request: a pending interrupt with no valid instruction simply
  // stays asserted until the next valid instruction picks it up.
  assign int_req_w = ie_w & ~exl_w & (|(ip_w & im_w));

  // --------------------------------------------------------------------------
  // Priority arbitration
  // --------------------------------------------------------------------------
  logic [4:0]  code_w;
  logic [31:0] badv_w;

  always_comb begin
    code_w = EXC_NONE;
    badv_w = 32'h0;
    if (mem_valid_i) begin
      if (int_req_w) begin
        code_w = EXC_INT;
      end else if (mem_exc_i[7]) begin
        code_w = EXC_ADEL;
        badv_w = mem_pc_i;
      end else if (mem_exc_i[6]) begin
        code_w = EXC_RI;
      end else if (mem_exc_i[5]) begin
        code_w = EXC_SYS;
      end else if (mem_exc_i[4]) begin
        code_w = EXC_BP;
      end else if (mem_exc_i[3]) begin
        code_w = EXC_OV;
      end else if (mem_exc_i[2]) begin
        code_w = EXC_ADEL;
        badv_w = mem_daddr_i;
      end else if (mem_exc_i[1]) begin
        code_w = EXC_ADES;
        badv_w = mem_daddr_i;
      end else if (mem_exc_i[0]) begin
        code_w = EXC_ERET;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output record FSM: RUN captures, BLANK shadows the flush cycle
  // --------------------------------------------------------------------------
  logic [0:0]  state_q,    state_d;
  logic [4:0]  exccode_q,  exccode_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] badv_q,     badv_d;
  logic        delay_q,    delay_d;

  always_comb begin
    state_d   = ST_RUN;
    exccode_d = EXC_NONE;
    pc_d      = 32'h0;
    badv_d    = 32'h0;
    delay_d   = 1'b0;
    if (state_q == ST_RUN) begin
      exccode_d = code_w;
      if (code_w != EXC_NONE) begin
        pc_d    = mem_pc_i;
        badv_d  = badv_w;
        delay_d = mem_in_delay_i;
        state_d = ST_BLANK;
      end
    end
    // ST_BLANK: the instruction now in MEM is being flushed; drop it.
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= ST_RUN;
      exccode_q <= EXC_NONE;
      pc_q      <= 32'h0;
      badv_q    <= 32'h0;
      delay_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      exccode_q <= exccode_d;
      pc_q      <= pc_d;
      badv_q    <= badv_d;
      delay_q   <= delay_d;
    end
  end

  assign exccode_o      = exccode_q;
  assign exc_pc_o       = pc_q;
  assign exc_badvaddr_o = badv_q;
  assign exc_in_delay_o = delay_q;

  // Register bits that carry no meaning for arbitration.
  logic unused_w;
  assign unused_w = &{1'b0, cp0_status_i, cp0_cause_i, cp0_wdata_i};

endmodule

`default_nettype wire

// File: tb/tb_mem_exc_arb.sv
// ============================================================================
// Module   : tb_mem_exc_arb
// Purpose  : Directed self-checking bench for mem_exc_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_exc_arb;

`ifdef INT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk;
  logic        rst;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delay;
  logic [7:0]  mem_exc;
  logic [31:0] mem_daddr;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [5:0]  hw_int;
  logic        timer_int;
  logic [5:0]  int_out;
  logic [4:0]  exccode;
  logic [31:0] exc_pc;
  logic [31:0] exc_badv;
  logic        exc_delay;

  int checks = 0;
  int errors = 0;

  mem_exc_arb dut (
    .cpu_clk_50M   (clk),
    .cpu_rst       (rst),
    .mem_valid_i   (mem_valid),
    .mem_pc_i      (mem_pc),
    .mem_in_delay_i(mem_in_delay),
    .mem_exc_i     (mem_exc),
    .mem_daddr_i   (mem_daddr),
    .cp0_status_i  (cp0_status),
    .cp0_cause_i   (cp0_cause),
    .cp0_we_i      (cp0_we),
    .cp0_waddr_i   (cp0_waddr),
    .cp0_wdata_i   (cp0_wdata),
    .hw_int_i      (hw_int),
    .timer_int_i   (timer_int),
    .int_o         (int_out),
    .exccode_o     (exccode),
    .exc_pc_o      (exc_pc),
    .exc_badvaddr_o(exc_badv),
    .exc_in_delay_o(exc_delay)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    mem_exc   = 8'h00;
    mem_in_delay = 1'b0;
    cp0_we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_valid = 1'b0; mem_pc = 32'h0; mem_in_delay = 1'b0; mem_exc = 8'h00;
    mem_daddr = 32'h0; cp0_status = 32'h1000FF01; cp0_cause = 32'h0;
    cp0_we = 1'b0; cp0_waddr = 5'd0; cp0_wdata = 32'h0;
    hw_int = 6'h00; timer_int = 1'b1;

    // Reset state
    step(); step();
    chk("rst_exccode", {27'h0, exccode}, 32'h10);
    chk("rst_pc", exc_pc, 32'h0);
    chk("rst_badv", exc_badv, 32'h0);
    chk("rst_delay", {31'h0, exc_delay}, 32'h0);
    chk("rst_int_timer", {26'h0, int_out}, 32'h20);
    timer_int = 1'b0;
    #1;
    chk("rst_int_idle", {26'h0, int_out}, 32'h00);
    rst = 1'b0;
    step();

    // Hardware interrupt on IP2 with a valid instruction waiting
    hw_int = 6'h01; mem_valid = 1'b1; mem_pc = 32'hBFC00100;
    for (int i = 0; i < SYNC_LAT; i++) begin
      step();
      chk("int_sync_wait", {27'h0, exccode}, 32'h10);
    end
    step();
    chk("int_code", {27'h0, exccode}, 32'h00);
    chk("int_pc", exc_pc, 32'hBFC00100);
    chk("int_vec", {26'h0, int_out}, 32'h01);
    hw_int = 6'h00; idle();
    step();
    chk("int_blank", {27'h0, exccode}, 32'h10);
    step();

    // OV beats ERET
    mem_valid = 1'b1; mem_exc = 8'b0000_1001; mem_pc = 32'h80000010;
    step();
    chk("ov_code", {27'h0, exccode}, 32'h0C);
    chk("ov_pc", exc_pc, 32'h80000010);
    chk("ov_badv", exc_badv, 32'h0);
    idle(); step(); step();

    // Store address error
    mem_valid = 1'b1; mem_exc = 8'b0000_0010; mem_pc = 32'h80000014;
    mem_daddr = 32'h80000003;
    step();
    chk("ades_code", {27'h0, exccode}, 32'h05);
    chk("ades_badv", exc_badv, 32'h80000003);
    idle(); step(); step();

    // Fetch address error outranks the load error; badvaddr is the PC
    mem_valid = 1'b1; mem_exc = 8'b1000_0100; mem_pc = 32'h80000044;
    step();
    chk("ifadel_code", {27'h0, exccode}, 32'h04);
    chk("ifadel_badv", exc_badv, 32'h80000044);
    idle(); step(); step();

    // Load address error: badvaddr is the data address
    mem_valid = 1'b1; mem_exc = 8'b0000_0101; mem_pc = 32'h80000048;
    step();
    chk("ldadel_code", {27'h0, exccode}, 32'h04);
    chk("ldadel_badv", exc_badv, 32'h80000003);
    idle(); step(); step();

    // RI outranks SYS and BP
    mem_valid = 1'b1; mem_exc = 8'b0111_0000;
    step();
    chk("ri_code", {27'h0, exccode}, 32'h0A);
    idle(); step(); step();

    // ERET alone
    mem_valid = 1'b1; mem_exc = 8'b0000_0001;
    step();
    chk("eret_code", {27'h0, exccode}, 32'h11);
    idle(); step(); step();

    // Flags on a bubble are ignored
    mem_valid = 1'b0; mem_exc = 8'b0010_0000;
    step();
    chk("bubble_code", {27'h0, exccode}, 32'h10);
    idle();

    // Interrupt pending over bubbles, then attaches to a delay-slot instr
    hw_int = 6'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pend_bubble", {27'h0, exccode}, 32'h10);
    end
    mem_valid = 1'b1; mem_pc = 32'h80000020; mem_in_delay = 1'b1;
    step();
    chk("pend_code", {27'h0, exccode}, 32'h00);
    chk("pend_pc", exc_pc, 32'h80000020);
    chk("pend_delay", {31'h0, exc_delay}, 32'h1);
    idle(); hw_int = 6'h00; step(); step();

    // IP2 pending with IM=0, then mtc0 unmasks it
    cp0_status = 32'h10000001; hw_int = 6'h01; mem_valid = 1'b1; mem_pc = 32'h80000030;
    for (int i = 0; i < SYNC_LAT + 1; i++) begin
      step();
      chk("masked_code", {27'h0, exccode}, 32'h10);
    end
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h1000FF01;
    step();
    chk("unmask_code", {27'h0, exccode}, 32'h00);
    chk("unmask_pc", exc_pc, 32'h80000030);
    idle(); step(); step();

    // mtc0 setting EXL suppresses the pending interrupt in the same cycle
    cp0_status = 32'h1000FF01; mem_valid = 1'b1;
    cp0_we = 1'b1; cp0_waddr = 5'd12; cp0_wdata = 32'h1000FF03;
    step();
    chk("exl_code", {27'h0, exccode}, 32'h10);
    // mtc0 clearing IE likewise
    cp0_wdata = 32'h1000FF00;
    step();
    chk("ie_code", {27'h0, exccode}, 32'h10);
    idle(); hw_int = 6'h00;

    // Software interrupt raised by an mtc0 to Cause
    mem_valid = 1'b1; cp0_we = 1'b1; cp0_waddr = 5'd13; cp0_wdata = 32'h00000100;
    step();
    chk("swint_code", {27'h0, exccode}, 32'h00);
    idle(); step(); step();

    // Back-to-back SYS: second one blanked, then reset mid-BLANK
    mem_valid = 1'b1; mem_exc = 8'b0010_0000; mem_pc = 32'h80000050;
    step();
    chk("sys1_code", {27'h0, exccode}, 32'h08);
    step();
    chk("sys2_blank", {27'h0, exccode}, 32'h10);
    chk("sys2_pc", exc_pc, 32'h0);
    step();
    chk("sys3_code", {27'h0, exccode}, 32'h08);
    chk("sys3_pc", exc_pc, 32'h80000050);
    rst = 1'b1;
    #1;
    chk("rstmid_code", {27'h0, exccode}, 32'h10);
    chk("rstmid_pc", exc_pc, 32'h0);
    #2;
    rst = 1'b0;
    step();
    // FSM back in RUN: the still-present SYS is captured, not blanked
    chk("rstmid_run", {27'h0, exccode}, 32'h08);
    idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
